koa_mult_pipe: RTL and testbench

//  Parametrised, pipelined Karatsuba-Ofman multiplier. Successor to the single-register-stage KOA

---
 rtl/koa_mult_pipe_pkg.sv | 15 +
 rtl/koa_mult_pipe_if.sv | 20 ++
 rtl/koa_mult_pipe_core.sv | 34 +++
 rtl/koa_mult_pipe.sv | 93 +++++++++
 tb/tb_koa_mult_pipe.sv | 145 ++++++++++++++
 5 files changed

// File: rtl/koa_mult_pipe_pkg.sv
// koa_mult_pipe_pkg: shared constants and split-width helpers for the KOA multiplier
//   KOA_LATENCY  fixed pipeline latency in cycles
//   KOA_SW_MIN/MAX  legal operand width range
//   koa_lo/koa_hi   low (ceil) and high (floor) halves of a width
package koa_mult_pipe_pkg;
   localparam int KOA_LATENCY = 3;
   localparam int KOA_SW_MIN = 4;
   localparam int KOA_SW_MAX = 64;
   function automatic int koa_lo(input int w);
      return (w + 1) / 2;
   endfunction
   function automatic int koa_hi(input int w);
      return w / 2;
   endfunction
endpackage

// File: rtl/koa_mult_pipe_if.sv
// koa_mult_pipe_if: request/response handshake bundle of the KOA multiplier
//   data_a, data_b  operands (SW bits)
//   signed_mode     1 = two's-complement operands
//   req_valid/req_ready  operand handshake
//   data_s          product (2*SW bits)
//   rsp_valid/rsp_ready  product handshake
interface koa_mult_pipe_if #(parameter int SW = 24);
   logic [SW-1:0] data_a;
   logic [SW-1:0] data_b;
   logic signed_mode;
   logic req_valid;
   logic req_ready;
   logic [2*SW-1:0] data_s;
   logic rsp_valid;
   logic rsp_ready;
   modport master (output data_a, data_b, signed_mode, req_valid, rsp_ready,
                   input req_ready, data_s, rsp_valid);
   modport slave (input data_a, data_b, signed_mode, req_valid, rsp_ready,
                  output req_ready, data_s, rsp_valid);
endinterface

// File: rtl/koa_mult_pipe_core.sv
// koa_core: purely combinational recursive Karatsuba-Ofman unsigned multiplier
//   a, b  unsigned operands (SW bits)
//   p     full product (2*SW bits)
module koa_core
   import koa_mult_pipe_pkg::*;
#(
   parameter int SW = 12,
   parameter int LEVELS = 1
) (
   input  logic [SW-1:0] a,
   input  logic [SW-1:0] b,
   output logic [2*SW-1:0] p
);
   localparam int W2 = 2 * SW;
   if (LEVELS == 0 || SW < 4) begin : g_leaf
      assign p = W2'(a) * W2'(b);
   end else begin : g_split
      localparam int L = koa_lo(SW);
      localparam int H = koa_hi(SW);
      logic [L:0] sum_a;
      logic [L:0] sum_b;
      logic [2*H-1:0] q_left;
      logic [2*L-1:0] q_right;
      logic [2*L+1:0] q_mid;
      logic [2*L+1:0] mid;
      assign sum_a = (L+1)'(a[L-1:0]) + (L+1)'(a[SW-1:L]);
      assign sum_b = (L+1)'(b[L-1:0]) + (L+1)'(b[SW-1:L]);
      koa_core #(.SW(H), .LEVELS(LEVELS-1)) u_left (.a(a[SW-1:L]), .b(b[SW-1:L]), .p(q_left));
      koa_core #(.SW(L), .LEVELS(LEVELS-1)) u_right (.a(a[L-1:0]), .b(b[L-1:0]), .p(q_right));
      koa_core #(.SW(L+1), .LEVELS(LEVELS-1)) u_mid (.a(sum_a), .b(sum_b), .p(q_mid));
      assign mid = q_mid - (2*L+2)'(q_left) - (2*L+2)'(q_right);
      assign p = (W2'(q_left) << (2*L)) + (W2'(mid) << L) + W2'(q_right);
   end
endmodule

// File: rtl/koa_mult_pipe.sv
// koa_mult_pipe: 3-stage pipelined signed/unsigned Karatsuba-Ofman multiplier with valid/ready
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  koa_mult_pipe_if.slave: operands/mode in, product out, both handshaked
module koa_mult_pipe
   import koa_mult_pipe_pkg::*;
#(
   parameter int SW = 24,
   parameter int LEVELS = 1
) (
   input logic clk,
   input logic rst,
   koa_mult_pipe_if.slave bus
);
   localparam int L = koa_lo(SW);
   localparam int H = koa_hi(SW);
   localparam int W2 = 2 * SW;
   if (SW < KOA_SW_MIN || SW > KOA_SW_MAX) begin : g_bad_sw
      $error("koa_mult_pipe: SW=%0d outside legal range", SW);
   end
   logic adv;
   logic s_a;
   logic s_b;
   logic [SW-1:0] abs_a;
   logic [SW-1:0] abs_b;
   logic [SW-1:0] mag_a;
   logic [SW-1:0] mag_b;
   logic neg1;
   logic v1;
   logic [L:0] sum_a;
   logic [L:0] sum_b;
   logic [2*H-1:0] q_left;
   logic [2*L-1:0] q_right;
   logic [2*L+1:0] q_mid;
   logic [2*H-1:0] q_left_r;
   logic [2*L-1:0] q_right_r;
   logic [2*L+1:0] q_mid_r;
   logic neg2;
   logic v2;
   logic [2*L+1:0] mid;
   logic [W2-1:0] prod;
   logic [W2-1:0] data_s;
   logic rsp_valid;
   // All stages move together; a stalled output freezes the whole pipe.
   assign adv = !rsp_valid || bus.rsp_ready;
   assign bus.req_ready = adv;
   assign bus.data_s = data_s;
   assign bus.rsp_valid = rsp_valid;
   // Magnitudes fit in SW unsigned bits, including -2^(SW-1).
   always_comb begin
      s_a = bus.signed_mode & bus.data_a[SW-1];
      s_b = bus.signed_mode & bus.data_b[SW-1];
      abs_a = s_a ? -bus.data_a : bus.data_a;
      abs_b = s_b ? -bus.data_b : bus.data_b;
   end
   assign sum_a = (L+1)'(mag_a[L-1:0]) + (L+1)'(mag_a[SW-1:L]);
   assign sum_b = (L+1)'(mag_b[L-1:0]) + (L+1)'(mag_b[SW-1:L]);
   koa_core #(.SW(H), .LEVELS(LEVELS)) u_left (.a(mag_a[SW-1:L]), .b(mag_b[SW-1:L]), .p(q_left));
   koa_core #(.SW(L), .LEVELS(LEVELS)) u_right (.a(mag_a[L-1:0]), .b(mag_b[L-1:0]), .p(q_right));
   koa_core #(.SW(L+1), .LEVELS(LEVELS)) u_mid (.a(sum_a), .b(sum_b), .p(q_mid));
   // Modular 2*SW arithmetic: the true product always fits, so truncation is exact.
   always_comb begin
      mid = q_mid_r - (2*L+2)'(q_left_r) - (2*L+2)'(q_right_r);
      prod = (W2'(q_left_r) << (2*L)) + (W2'(mid) << L) + W2'(q_right_r);
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mag_a <= '0;
         mag_b <= '0;
         neg1 <= 1'b0;
         v1 <= 1'b0;
         q_left_r <= '0;
         q_right_r <= '0;
         q_mid_r <= '0;
         neg2 <= 1'b0;
         v2 <= 1'b0;
         data_s <= '0;
         rsp_valid <= 1'b0;
      end else if (adv) begin
         mag_a <= abs_a;
         mag_b <= abs_b;
         neg1 <= s_a ^ s_b;
         v1 <= bus.req_valid;
         q_left_r <= q_left;
         q_right_r <= q_right;
         q_mid_r <= q_mid;
         neg2 <= neg1;
         v2 <= v1;
         data_s <= neg2 ? -prod : prod;
         rsp_valid <= v2;
      end
   end
endmodule

// File: tb/tb_koa_mult_pipe.sv
// tb_koa_mult_pipe: directed and randomized self-checking bench for koa_mult_pipe
module tb_koa_mult_pipe;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;
   koa_mult_pipe_if #(.SW(24)) if24 ();
   koa_mult_pipe_if #(.SW(23)) if23 ();
   koa_mult_pipe #(.SW(24), .LEVELS(1)) dut24 (.clk(clk), .rst(rst), .bus(if24));
   koa_mult_pipe #(.SW(23), .LEVELS(2)) dut23 (.clk(clk), .rst(rst), .bus(if23));
   int n_chk = 0;
   int n_fail = 0;
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   // Reference product: sign-extend to 64 bits, multiply, keep 2*w bits.
   function automatic logic [63:0] model(input logic [63:0] a, input logic [63:0] b,
                                         input bit s, input int w);
      logic [63:0] x;
      logic [63:0] y;
      logic [63:0] p;
      x = (s && a[w-1]) ? (a | (~64'd0 << w)) : a;
      y = (s && b[w-1]) ? (b | (~64'd0 << w)) : b;
      p = x * y;
      return p & ((64'd1 << (2 * w)) - 64'd1);
   endfunction
   task automatic run24(input logic [23:0] a, input logic [23:0] b, input bit s,
                        input logic [63:0] exp, input string tag);
      int lat = 0;
      if24.data_a = a;
      if24.data_b = b;
      if24.signed_mode = s;
      if24.req_valid = 1'b1;
      if24.rsp_ready = 1'b1;
      #1;
      chk({tag, "_ready"}, 64'(if24.req_ready), 64'd1);
      for (int k = 1; k <= 8 && lat == 0; k++) begin
         @(posedge clk);
         #1;
         if (k == 1) if24.req_valid = 1'b0;
         if (if24.rsp_valid) lat = k;
      end
      chk({tag, "_latency"}, 64'(lat), 64'd3);
      chk({tag, "_data"}, 64'(if24.data_s), exp);
   endtask
   function automatic logic [22:0] pick23();
      int sel = $urandom_range(0, 7);
      return sel == 0 ? 23'd0 : sel == 1 ? 23'h7FFFFF : sel == 2 ? 23'h400000 :
             sel == 3 ? 23'd1 : 23'($urandom);
   endfunction
   task automatic stream23(input int n, input bit stall);
      int sent = 0;
      int got = 0;
      int cyc = 0;
      bit was_stall = 1'b0;
      logic [45:0] held = '0;
      logic [63:0] q[$];
      while (got < n && cyc < 2 * n + 50) begin
         if23.req_valid = sent < n;
         if23.data_a = pick23();
         if23.data_b = pick23();
         if23.signed_mode = 1'($urandom);
         if23.rsp_ready = stall ? !(cyc >= 4 && cyc < 7) : ($urandom_range(0, 7) != 0);
         #1;
         if (was_stall) begin
            chk("stall_valid", 64'(if23.rsp_valid), 64'd1);
            chk("stall_hold", 64'(if23.data_s), 64'(held));
         end
         chk("ready_o", 64'(if23.req_ready), 64'(!if23.rsp_valid || if23.rsp_ready));
         was_stall = if23.rsp_valid && !if23.rsp_ready;
         held = if23.data_s;
         if (if23.req_valid && if23.req_ready) begin
            q.push_back(model(64'(if23.data_a), 64'(if23.data_b), if23.signed_mode, 23));
            sent++;
         end
         if (if23.rsp_valid && if23.rsp_ready) begin
            if (q.size() == 0) chk("unexpected_output", 64'd1, 64'd0);
            else chk("stream_data", 64'(if23.data_s), q.pop_front());
            got++;
         end
         @(posedge clk);
         #1;
         cyc++;
      end
      if23.req_valid = 1'b0;
      chk("stream_count", 64'(got), 64'(n));
      chk("stream_leftover", 64'(q.size()), 64'd0);
   endtask
   initial begin
      if24.data_a = '0;
      if24.data_b = '0;
      if24.signed_mode = 1'b0;
      if24.req_valid = 1'b0;
      if24.rsp_ready = 1'b0;
      if23.data_a = '0;
      if23.data_b = '0;
      if23.signed_mode = 1'b0;
      if23.req_valid = 1'b0;
      if23.rsp_ready = 1'b0;
      rst = 1'b1;
      #12;
      chk("reset_valid", 64'(if24.rsp_valid), 64'd0);
      chk("reset_data", 64'(if24.data_s), 64'd0);
      chk("reset_ready", 64'(if24.req_ready), 64'd1);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      run24(24'hFFFFFF, 24'hFFFFFF, 1'b0, 64'hFFFFFE000001, "umax");
      run24(24'h800000, 24'h800000, 1'b1, 64'h400000000000, "smin_sq");
      run24(24'hFFFFFF, 24'h000001, 1'b1, 64'hFFFFFFFFFFFF, "neg_one");
      run24(24'h000000, 24'h800000, 1'b1, 64'd0, "szero");
      run24(24'hFFFFFF, 24'h000000, 1'b1, 64'd0, "negzero");
      run24(24'h000001, 24'h800000, 1'b0, 64'h000000800000, "u_one");
      run24(24'h123456, 24'hFEDCBA, 1'b1, model(64'h123456, 64'hFEDCBA, 1'b1, 24), "mixed");
      for (int i = 0; i < 3; i++) begin
         if24.data_a = 24'(i + 2);
         if24.data_b = 24'(i + 3);
         if24.signed_mode = 1'b0;
         if24.req_valid = 1'b1;
         if24.rsp_ready = 1'b1;
         @(posedge clk);
         #1;
      end
      if24.req_valid = 1'b0;
      chk("inflight_valid", 64'(if24.rsp_valid), 64'd1);
      #2 rst = 1'b1;
      #1;
      chk("async_rst_valid", 64'(if24.rsp_valid), 64'd0);
      chk("async_rst_data", 64'(if24.data_s), 64'd0);
      chk("async_rst_ready", 64'(if24.req_ready), 64'd1);
      @(posedge clk);
      #3 rst = 1'b0;
      @(posedge clk);
      #1;
      run24(24'd5, 24'd7, 1'b0, 64'd35, "post_reset");
      stream23(8, 1'b1);
      stream23(10000, 1'b0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
